// File: rtl/mem_access.sv
// mem_access: RISC-V MEM stage with bus handshake, load/store formatting and MEM/WB register (optional MEM_MISALIGN_TRAP_EN)
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              ctrl_wb_RegWrite_i,
  input  logic              ctrl_wb_Mem2Reg_i,
  input  logic              ctrl_mem_read_i,
  input  logic              ctrl_mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] mem_write_data_i,
  input  logic [4:0]        write_addr_i,
  output logic              stall_o,
  output logic              valid_o,
  output logic              wb_RegWrite_o,
  output logic              wb_Mem2Reg_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic [4:0]        write_addr_o,
  output logic              misalign_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  output logic [3:0]        dbus_be_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [DATA_W-1:0] dbus_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] alu_q, wd_q, ld_data;
  logic [2:0] f3_q;
  logic we_q, rw_q, m2r_q, mem_op, trap, accept, done_st, done_ld;
  logic [4:0] wa_q;
  logic [7:0] lb;
  logic [15:0] lh;
  assign mem_op = valid_i & (ctrl_mem_read_i | ctrl_mem_write_i);
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op & ((funct3_i[1:0] == 2'b01 & alu_result_i[0]) | (funct3_i[1] & |alu_result_i[1:0]));
`else
  assign trap = 1'b0;
`endif
  assign accept  = state == IDLE & mem_op & !trap;
  assign done_st = state == REQ & dbus_gnt_i & we_q;
  assign done_ld = state == WAIT_R & dbus_rvalid_i;
  assign dbus_req_o   = state == REQ;
  assign dbus_we_o    = dbus_req_o & we_q;
  assign dbus_addr_o  = {alu_q[ADDR_W-1:2], 2'b00};
  assign dbus_wdata_o = f3_q[1:0] == 2'b00 ? {4{wd_q[7:0]}} : f3_q[1:0] == 2'b01 ? {2{wd_q[15:0]}} : wd_q;
  assign dbus_be_o    = !dbus_req_o ? 4'b0000 : f3_q[1:0] == 2'b00 ? 4'b0001 << alu_q[1:0] :
                        f3_q[1:0] == 2'b01 ? 4'b0011 << alu_q[1:0] : 4'b1111;
  assign lb = alu_q[1:0] == 2'd0 ? dbus_rdata_i[7:0] : alu_q[1:0] == 2'd1 ? dbus_rdata_i[15:8] :
              alu_q[1:0] == 2'd2 ? dbus_rdata_i[23:16] : dbus_rdata_i[31:24];
  assign lh = alu_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
  assign ld_data = f3_q[1:0] == 2'b00 ? {{24{!f3_q[2] & lb[7]}}, lb} :
                   f3_q[1:0] == 2'b01 ? {{16{!f3_q[2] & lh[15]}}, lh} : dbus_rdata_i;
  // state register; reset abandons any access in flight
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and combinational stall toward the front of the pipeline
  always_comb begin
    state_n = state;
    stall_o = 1'b0;
    state_n = state == IDLE ? (accept ? REQ : IDLE) :
              state == REQ ? (dbus_gnt_i ? (we_q ? IDLE : WAIT_R) : REQ) :
              (dbus_rvalid_i ? IDLE : WAIT_R);
    stall_o = accept | (state == REQ & !(dbus_gnt_i & we_q)) | (state == WAIT_R & !dbus_rvalid_i);
  end
  // capture the access when it is accepted; a read wins over a write
  always_ff @(posedge clk)
    if (rst) begin
      alu_q <= '0;
      wd_q  <= '0;
      f3_q  <= '0;
      we_q  <= 1'b0;
      rw_q  <= 1'b0;
      m2r_q <= 1'b0;
      wa_q  <= '0;
    end else if (accept) begin
      alu_q <= alu_result_i;
      wd_q  <= mem_write_data_i;
      f3_q  <= funct3_i;
      we_q  <= ctrl_mem_write_i & !ctrl_mem_read_i;
      rw_q  <= ctrl_wb_RegWrite_i;
      m2r_q <= ctrl_wb_Mem2Reg_i;
      wa_q  <= write_addr_i;
    end
  // MEM/WB register: single-cycle valid pulse on completion, otherwise hold
  always_ff @(posedge clk)
    if (rst) begin
      valid_o       <= 1'b0;
      wb_RegWrite_o <= 1'b0;
      wb_Mem2Reg_o  <= 1'b0;
      alu_result_o  <= '0;
      mem_rdata_o   <= '0;
      write_addr_o  <= '0;
      misalign_o    <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      if (state == IDLE & valid_i & !accept) begin
        valid_o       <= 1'b1;
        wb_RegWrite_o <= ctrl_wb_RegWrite_i & !trap;
        wb_Mem2Reg_o  <= ctrl_wb_Mem2Reg_i;
        alu_result_o  <= alu_result_i;
        mem_rdata_o   <= '0;
        write_addr_o  <= write_addr_i;
        misalign_o    <= trap;
      end
      if (done_st | done_ld) begin
        valid_o       <= 1'b1;
        wb_RegWrite_o <= rw_q;
        wb_Mem2Reg_o  <= m2r_q;
        alu_result_o  <= alu_q;
        mem_rdata_o   <= done_ld ? ld_data : '0;
        write_addr_o  <= wa_q;
      end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed table-driven bench for mem_access plus multi-cycle handshake sequences
module tb_mem_access;
  logic clk = 1'b0, rst = 1'b1;
  logic valid_i = 0, rw_i = 0, m2r_i = 0, rd_i = 0, wr_i = 0;
  logic [2:0] f3_i = 0;
  logic [31:0] alu_i = 0, wd_i = 0, rdata_i = 0;
  logic [4:0] wa_i = 0;
  logic gnt_i = 0, rvalid_i = 0;
  logic stall_o, valid_o, wb_RegWrite_o, wb_Mem2Reg_o, misalign_o, dbus_req_o, dbus_we_o;
  logic [31:0] alu_result_o, mem_rdata_o, dbus_addr_o, dbus_wdata_o;
  logic [4:0] write_addr_o;
  logic [3:0] dbus_be_o;
  int checks = 0, failures = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ctrl_wb_RegWrite_i(rw_i), .ctrl_wb_Mem2Reg_i(m2r_i),
    .ctrl_mem_read_i(rd_i), .ctrl_mem_write_i(wr_i), .funct3_i(f3_i), .alu_result_i(alu_i),
    .mem_write_data_i(wd_i), .write_addr_i(wa_i), .stall_o(stall_o), .valid_o(valid_o),
    .wb_RegWrite_o(wb_RegWrite_o), .wb_Mem2Reg_o(wb_Mem2Reg_o), .alu_result_o(alu_result_o),
    .mem_rdata_o(mem_rdata_o), .write_addr_o(write_addr_o), .misalign_o(misalign_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_gnt_i(gnt_i),
    .dbus_rvalid_i(rvalid_i), .dbus_rdata_i(rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] addr, wd, rdata;
    logic [4:0] wa;
    logic rw, m2r;
    logic [3:0] be;
    logic [31:0] ewd, erd;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] wa, input logic rw, input logic m2r);
    valid_i = 1; rd_i = rd; wr_i = wr; f3_i = f3; alu_i = a; wd_i = wd; wa_i = wa; rw_i = rw; m2r_i = m2r;
  endtask

  task automatic run_vec(input vec_t x);
    logic mem, ld;
    mem = x.rd | x.wr;
    ld = x.rd;
    drive(x.rd, x.wr, x.f3, x.addr, x.wd, x.wa, x.rw, x.m2r);
    #1 chk("stall_accept", stall_o, mem);
    tick();
    if (mem) begin
      chk("req", dbus_req_o, 1);
      chk("addr", dbus_addr_o, {x.addr[31:2], 2'b00});
      chk("we", dbus_we_o, !ld);
      chk("valid_early", valid_o, 0);
      if (!ld) begin
        chk("be", dbus_be_o, x.be);
        chk("wdata", dbus_wdata_o, x.ewd);
      end
      gnt_i = 1;
      #1 chk("stall_gnt", stall_o, ld);
      tick();
      gnt_i = 0;
      if (ld) begin
        chk("req_drop", dbus_req_o, 0);
        rvalid_i = 1; rdata_i = x.rdata;
        #1 chk("stall_rvalid", stall_o, 0);
        tick();
        rvalid_i = 0; rdata_i = 0;
      end
    end
    chk("valid", valid_o, 1);
    chk("regwrite", wb_RegWrite_o, x.rw);
    chk("mem2reg", wb_Mem2Reg_o, x.m2r);
    chk("alu_result", alu_result_o, x.addr);
    chk("write_addr", write_addr_o, x.wa);
    chk("rdata", mem_rdata_o, ld ? x.erd : 32'h0);
    chk("misalign", misalign_o, 0);
    valid_i = 0;
    tick();
    chk("valid_pulse", valid_o, 0);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 3'd0, 32'h12345678, 32'h0,        32'h0,        5'd5,  1, 0, 4'h0, 32'h0,        32'h0};
    tbl[1]  = '{0, 1, 3'd2, 32'h00000100, 32'hDEADBEEF, 32'h0,        5'd1,  1, 0, 4'hF, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{0, 1, 3'd0, 32'h00000103, 32'h000000A5, 32'h0,        5'd2,  0, 0, 4'h8, 32'hA5A5A5A5, 32'h0};
    tbl[3]  = '{0, 1, 3'd1, 32'h00000102, 32'h1234BEEF, 32'h0,        5'd3,  0, 0, 4'hC, 32'hBEEFBEEF, 32'h0};
    tbl[4]  = '{1, 0, 3'd0, 32'h00000102, 32'h0,        32'h0080FF00, 5'd7,  1, 1, 4'h0, 32'h0,        32'hFFFFFF80};
    tbl[5]  = '{1, 0, 3'd4, 32'h00000102, 32'h0,        32'h0080FF00, 5'd8,  1, 1, 4'h0, 32'h0,        32'h00000080};
    tbl[6]  = '{1, 0, 3'd5, 32'h00000102, 32'h0,        32'h0080FF00, 5'd10, 1, 1, 4'h0, 32'h0,        32'h00000080};
    tbl[7]  = '{1, 0, 3'd1, 32'h00000100, 32'h0,        32'h00008001, 5'd11, 1, 1, 4'h0, 32'h0,        32'hFFFF8001};
    tbl[8]  = '{1, 0, 3'd2, 32'h00000204, 32'h0,        32'hCAFEF00D, 5'd12, 1, 1, 4'h0, 32'h0,        32'hCAFEF00D};
    tbl[9]  = '{1, 0, 3'd0, 32'h00000101, 32'h0,        32'h00007F00, 5'd13, 1, 1, 4'h0, 32'h0,        32'h0000007F};
    tbl[10] = '{1, 1, 3'd2, 32'h00000108, 32'h00000055, 32'h11223344, 5'd14, 1, 1, 4'h0, 32'h0,        32'h11223344};
    tick();
    tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_req", dbus_req_o, 0);
    chk("rst_we", dbus_we_o, 0);
    chk("rst_addr", dbus_addr_o, 0);
    chk("rst_wdata", dbus_wdata_o, 0);
    chk("rst_be", dbus_be_o, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_misalign", misalign_o, 0);
    rst = 0;
    tick();
    foreach (tbl[i]) run_vec(tbl[i]);

    // LW: grant after three waiting cycles, rvalid two cycles after grant, stray rvalid in REQ
    drive(1, 0, 3'd2, 32'h00000300, 32'h0, 5'd9, 1, 1);
    #1 chk("lw_stall_accept", stall_o, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_req_held", dbus_req_o, 1);
      chk("lw_addr_held", dbus_addr_o, 32'h300);
      chk("lw_stall_req", stall_o, 1);
      chk("lw_no_valid", valid_o, 0);
      if (i == 1) begin rvalid_i = 1; rdata_i = 32'hBAD0BAD0; end
      tick();
      rvalid_i = 0; rdata_i = 0;
    end
    chk("lw_req_gnt", dbus_req_o, 1);
    gnt_i = 1;
    #1 chk("lw_stall_gnt", stall_o, 1);
    tick();
    gnt_i = 0;
    chk("lw_wait_noreq", dbus_req_o, 0);
    chk("lw_wait_stall", stall_o, 1);
    chk("lw_wait_novalid", valid_o, 0);
    tick();
    chk("lw_wait2_stall", stall_o, 1);
    rvalid_i = 1; rdata_i = 32'h0BADF00D;
    #1 chk("lw_stall_rvalid", stall_o, 0);
    tick();
    rvalid_i = 0; rdata_i = 0;
    chk("lw_valid", valid_o, 1);
    chk("lw_rdata", mem_rdata_o, 32'h0BADF00D);
    chk("lw_wa", write_addr_o, 9);
    valid_i = 0;
    tick();
    chk("lw_valid_pulse", valid_o, 0);

    // reset while waiting for read data
    drive(1, 0, 3'd2, 32'h00000400, 32'h0, 5'd15, 1, 1);
    tick();
    gnt_i = 1;
    tick();
    gnt_i = 0;
    valid_i = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_req", dbus_req_o, 0);
    chk("rst_mid_valid", valid_o, 0);
    chk("rst_mid_stall", stall_o, 0);
    rvalid_i = 1; rdata_i = 32'h77777777;
    tick();
    rvalid_i = 0; rdata_i = 0;
    chk("rst_late_rvalid_valid", valid_o, 0);
    chk("rst_late_rvalid_req", dbus_req_o, 0);
    run_vec(tbl[0]);

    // back-to-back: store completes, load accepted in the completion cycle
    drive(0, 1, 3'd2, 32'h00000500, 32'h01020304, 5'd16, 0, 0);
    tick();
    gnt_i = 1;
    tick();
    gnt_i = 0;
    chk("b2b_st_valid", valid_o, 1);
    drive(1, 0, 3'd0, 32'h00000504, 32'h0, 5'd17, 1, 1);
    #1 chk("b2b_ld_stall", stall_o, 1);
    tick();
    chk("b2b_ld_req", dbus_req_o, 1);
    chk("b2b_ld_addr", dbus_addr_o, 32'h504);
    chk("b2b_ld_we", dbus_we_o, 0);
    chk("b2b_no_valid", valid_o, 0);
    gnt_i = 1;
    tick();
    gnt_i = 0;
    rvalid_i = 1; rdata_i = 32'h000000F0;
    tick();
    rvalid_i = 0; rdata_i = 0;
    chk("b2b_ld_valid", valid_o, 1);
    chk("b2b_ld_rdata", mem_rdata_o, 32'hFFFFFFF0);
    chk("b2b_ld_wa", write_addr_o, 17);
    valid_i = 0;
    tick();

    // misaligned halfword load at 0x101
    drive(1, 0, 3'd1, 32'h00000101, 32'h0, 5'd18, 1, 1);
`ifdef MEM_MISALIGN_TRAP_EN
    #1 chk("mis_stall", stall_o, 0);
    tick();
    valid_i = 0;
    chk("mis_noreq", dbus_req_o, 0);
    chk("mis_valid", valid_o, 1);
    chk("mis_flag", misalign_o, 1);
    chk("mis_regwrite", wb_RegWrite_o, 0);
    tick();
    chk("mis_flag_pulse", misalign_o, 0);
    chk("mis_noreq2", dbus_req_o, 0);
`else
    #1 chk("mis_stall", stall_o, 1);
    tick();
    chk("mis_req", dbus_req_o, 1);
    chk("mis_addr", dbus_addr_o, 32'h100);
    chk("mis_be", dbus_be_o, 4'b0110);
    gnt_i = 1;
    tick();
    gnt_i = 0;
    rvalid_i = 1; rdata_i = 32'h00ABCD00;
    tick();
    rvalid_i = 0; rdata_i = 0;
    valid_i = 0;
    chk("mis_valid", valid_o, 1);
    chk("mis_flag", misalign_o, 0);
    chk("mis_regwrite", wb_RegWrite_o, 1);
    tick();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access (MEM) stage of the pipelined RISC-V core. It consumes the EX/MEM register outputs and performs loads and stores on the data bus with a request/grant/response handshake. It formats byte, halfword and word data and stalls the front of the pipeline while an access is outstanding. Results are registered toward the MEM/WB register, so this block also provides the MEM→WB boundary.

## Interface
Parameters:
- ADDR_W, 32, data address width
- DATA_W, 32, data bus width (fixed at 32; 4 byte lanes)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  EX/MEM slot holds a live instruction
- ctrl_wb_RegWrite_i  in  1  writeback enable
- ctrl_wb_Mem2Reg_i  in  1  writeback selects memory data
- ctrl_mem_read_i  in  1  load
- ctrl_mem_write_i  in  1  store
- funct3_i  in  3  access size/sign
- alu_result_i  in  32  effective address / ALU result
- mem_write_data_i  in  32  store data (rs2)
- write_addr_i  in  5  destination register
- stall_o  out  1  hold EX/MEM and earlier stages
- valid_o  out  1  MEM/WB slot valid
- wb_RegWrite_o  out  1  writeback enable to WB
- wb_Mem2Reg_o  out  1  writeback source select
- alu_result_o  out  32  registered ALU result
- mem_rdata_o  out  32  formatted load data
- write_addr_o  out  5  destination register
- misalign_o  out  1  one-cycle misaligned-access flag
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  bus write
- dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_be_o  out  4  byte enables
- dbus_gnt_i  in  1  request accepted
- dbus_rvalid_i  in  1  read data valid
- dbus_rdata_i  in  32  read data

## Operation
- FSM states: IDLE, REQ, WAIT_R.
- IDLE, valid_i with neither read nor write: register the pass-through fields. Set valid_o=1 and mem_rdata_o=0. stall_o=0.
- IDLE, valid_i with read or write: latch address, funct3, store data and writeback fields, then go to REQ. If both read and write are set, the access is a read.
- REQ: dbus_req_o=1 with address, we, be and wdata held stable until dbus_gnt_i.
  - Store granted: complete and return to IDLE.
  - Load granted: go to WAIT_R.
- WAIT_R: wait for dbus_rvalid_i. Format the load, complete, and return to IDLE. Any dbus_rvalid_i seen in IDLE or REQ is ignored.
- Store lanes (funct3):
  - 000 SB: be = 0001<<addr[1:0]; wdata = byte replicated ×4.
  - 001 SH: be = 0011<<addr[1:0]; wdata = halfword replicated ×2.
  - 010 SW: be = 1111; wdata unchanged.
- Load formatting (funct3):
  - 000 LB: byte at lane addr[1:0], sign-extended.
  - 100 LBU: byte at lane addr[1:0], zero-extended.
  - 001 LH: halfword at addr[1], sign-extended.
  - 101 LHU: halfword at addr[1], zero-extended.
  - 010 LW: full word.
  - Other funct3 values are treated as LW/SW.
- Completion: next edge sets valid_o=1 with the latched writeback fields. mem_rdata_o is loaded for loads and 0 for stores.
- No completion in a cycle: valid_o=0 next cycle and the other outputs hold.
- Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]≠0.

## Timing
- Reset values: valid_o, wb_RegWrite_o, wb_Mem2Reg_o, misalign_o, dbus_req_o, dbus_we_o = 0. All buses = 0. stall_o = 0. State = IDLE.
- Reset mid-access drops dbus_req_o on the next edge and abandons the access. No valid_o results from it.
- stall_o = (IDLE & valid_i & (read|write)) | (REQ & !(gnt & write)) | (WAIT_R & !rvalid). It is combinational.
- Inputs are sampled only in IDLE. Upstream holds them stable while stall_o=1.
- Non-memory op: 1-cycle latency.
- Store with immediate grant, accepted at cycle T: req at T+1, valid_o at T+2, stall_o high at T only.
- Load with immediate grant and rvalid one cycle after grant: valid_o at T+3.
- Back-to-back memory ops: the next access is accepted the cycle after completion.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access issues no bus request and stays in IDLE.
  - misalign_o pulses for one cycle with valid_o=1 and wb_RegWrite_o=0.
  - Latency is 1 cycle.
- Undefined: address low bits are ignored. The access proceeds to the aligned word with the lane computed from addr[1:0] as above. misalign_o stays 0.

## Test plan
- SW addr 0x100 data 0xDEADBEEF, gnt immediate -> dbus_addr 0x100, be 1111, wdata 0xDEADBEEF; valid_o at T+2, wb_RegWrite_o as input.
- SB addr 0x103 data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5.
- LB addr 0x102, rdata 0x0080FF00 -> mem_rdata_o 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x00000080.
- LW with gnt delayed 3 cycles and rvalid 2 cycles later -> req held stable, stall_o high throughout, valid_o exactly one cycle after rvalid.
- rst asserted while in WAIT_R, then rvalid arrives -> dbus_req_o=0, no valid_o, FSM in IDLE.
- LH addr 0x101 with MEM_MISALIGN_TRAP_EN -> no dbus_req_o, misalign_o=1 one cycle, wb_RegWrite_o=0. Without the macro -> request to 0x100, be 0110.
